// File: rtl/usb_edge_sync.sv
// Multi-channel line synchroniser, glitch filter and edge detector for the USB receive
// front end, with edge-to-edge interval measurement and line-idle detection.
module usb_edge_sync #(
   parameter int NCH         = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   din,
   input  logic             filt_en,
   input  logic [1:0]       edge_mode,
   output logic [NCH-1:0]   data_out,
   output logic [NCH-1:0]   rise_vec,
   output logic [NCH-1:0]   fall_vec,
   output logic [NCH-1:0]   edge_vec,
   output logic             edge_found,
   output logic [CNT_W-1:0] interval,
   output logic             interval_valid,
   output logic             idle
);

   localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);
   localparam logic [CNT_W-1:0]  GAP_MAX   = '1;

   logic [SYNC_STAGES-1:0][NCH-1:0] sync_reg;
   logic [NCH-1:0]   s;
   logic [NCH-1:0]   stable;
   logic [NCH-1:0]   stable_d_reg;
   logic             filt_en_d_reg;
   logic             filt_change;
   logic [NCH-1:0]   rise;
   logic [NCH-1:0]   fall;
   logic [NCH-1:0]   qual;
   logic             any_edge;
   logic [CNT_W-1:0] gap_reg;
   logic [CNT_W:0]   gap_plus;
   logic [CNT_W-1:0] gap_sat;
   logic [CNT_W-1:0] gap_next;
   logic [CNT_W-1:0] interval_reg;
   logic             interval_valid_reg;
   logic             idle_reg;
   logic             first_seen_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg      <= '0;
         filt_en_d_reg <= 1'b0;
      end else begin
         sync_reg      <= {sync_reg[SYNC_STAGES-2:0], din};
         filt_en_d_reg <= filt_en;
      end
   end

   assign s           = sync_reg[SYNC_STAGES-1];
   assign filt_change = filt_en ^ filt_en_d_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_filt
         logic [FCNT_W-1:0] cnt_reg;
         logic              stable_bit_reg;

         // A mode switch restarts the run count; the accepted level is left alone.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg        <= '0;
               stable_bit_reg <= 1'b0;
            end else if (filt_change) begin
               cnt_reg <= '0;
            end else if (!filt_en) begin
               cnt_reg        <= '0;
               stable_bit_reg <= s[gi];
            end else if (s[gi] == stable_bit_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == FILT_LAST) begin
               cnt_reg        <= '0;
               stable_bit_reg <= s[gi];
            end else begin
               cnt_reg <= cnt_reg + FCNT_W'(1);
            end
         end

         assign stable[gi] = stable_bit_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable_d_reg <= '0;
      end else begin
         stable_d_reg <= stable;
      end
   end

   assign rise = stable & ~stable_d_reg;
   assign fall = ~stable & stable_d_reg;

   always_comb begin
      qual = '0;
      case (edge_mode)
         2'b00:   qual = rise | fall;
         2'b01:   qual = rise;
         2'b10:   qual = fall;
         default: qual = '0;
      endcase
   end

   assign any_edge = |qual;

   // gap_reg never exceeds GAP_MAX, so the carry alone marks saturation.
   assign gap_plus = {1'b0, gap_reg} + (CNT_W + 1)'(1);
   assign gap_sat  = gap_plus[CNT_W] ? GAP_MAX : gap_plus[CNT_W-1:0];
   assign gap_next = any_edge ? '0 : gap_sat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gap_reg            <= '0;
         interval_reg       <= '0;
         interval_valid_reg <= 1'b0;
         idle_reg           <= 1'b0;
         first_seen_reg     <= 1'b0;
      end else begin
         gap_reg            <= gap_next;
         idle_reg           <= (gap_next == GAP_MAX);
         interval_valid_reg <= any_edge & first_seen_reg;
         if (any_edge) begin
            first_seen_reg <= 1'b1;
            if (first_seen_reg) begin
               interval_reg <= gap_sat;
            end
         end
      end
   end

   assign data_out       = stable;
   assign rise_vec       = rise;
   assign fall_vec       = fall;
   assign edge_vec       = qual;
   assign edge_found     = any_edge;
   assign interval       = interval_reg;
   assign interval_valid = interval_valid_reg;
   assign idle           = idle_reg;

endmodule

// File: tb/tb_usb_edge_sync.sv
// Directed bench for usb_edge_sync: a per-cycle behavioural model plus hand-computed
// checks on latency, glitch rejection, mode masking, interval, idle and reset.
module tb_usb_edge_sync;

   localparam int NCH  = 2;
   localparam int SS   = 2;
   localparam int FL   = 2;
   localparam int CW   = 8;
   localparam int GMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NCH-1:0] din = '0;
   logic          filt_en = 1'b1;
   logic [1:0]    edge_mode = 2'b00;
   logic [NCH-1:0] data_out, rise_vec, fall_vec, edge_vec;
   logic          edge_found;
   logic [CW-1:0] interval;
   logic          interval_valid;
   logic          idle;

   usb_edge_sync #(.NCH(NCH), .SYNC_STAGES(SS), .FILT_LEN(FL), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .din(din), .filt_en(filt_en), .edge_mode(edge_mode),
      .data_out(data_out), .rise_vec(rise_vec), .fall_vec(fall_vec), .edge_vec(edge_vec),
      .edge_found(edge_found), .interval(interval), .interval_valid(interval_valid),
      .idle(idle)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [NCH-1:0] m_sync [SS];
   logic [NCH-1:0] m_lvl, m_prev;
   int             m_run [NCH];
   logic           m_fe, m_armed, m_ivalid;
   int             m_cyc, m_last, m_quiet, m_interval;

   // activity counters observed on the DUT
   int ef_cnt = 0, iv_cnt = 0, iv_last = 0;
   int rise_cnt [NCH], fall_cnt [NCH], edge_cnt [NCH];

   function automatic logic [NCH-1:0] qualify(input logic [NCH-1:0] r, input logic [NCH-1:0] f,
                                              input logic [1:0] mode);
      case (mode)
         2'b00:   return r | f;
         2'b01:   return r;
         2'b10:   return f;
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic model_loop();
      logic [NCH-1:0] r, f, q, s;
      forever begin
         @(posedge clk);
         if (!rst) begin
            for (int k = 0; k < SS; k++) m_sync[k] = '0;
            for (int c = 0; c < NCH; c++) m_run[c] = 0;
            m_lvl = '0; m_prev = '0; m_fe = 1'b0; m_armed = 1'b0; m_ivalid = 1'b0;
            m_cyc = 0; m_last = 0; m_quiet = 0; m_interval = 0;
         end else begin
            r = m_lvl & ~m_prev;
            f = ~m_lvl & m_prev;
            q = qualify(r, f, edge_mode);
            m_ivalid = 1'b0;
            if (q != '0) begin
               if (m_armed) begin
                  m_interval = (m_cyc - m_last > GMAX) ? GMAX : (m_cyc - m_last);
                  m_ivalid = 1'b1;
               end
               m_armed = 1'b1;
               m_last  = m_cyc;
               m_quiet = 0;
            end else if (m_quiet < GMAX) begin
               m_quiet++;
            end
            s = m_sync[SS-1];
            m_prev = m_lvl;
            for (int c = 0; c < NCH; c++) begin
               if (filt_en != m_fe) begin
                  m_run[c] = 0;
               end else if (!filt_en) begin
                  m_lvl[c] = s[c];
                  m_run[c] = 0;
               end else if (s[c] == m_lvl[c]) begin
                  m_run[c] = 0;
               end else begin
                  m_run[c]++;
                  if (m_run[c] >= FL) begin
                     m_lvl[c] = s[c];
                     m_run[c] = 0;
                  end
               end
            end
            m_fe = filt_en;
            for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = din;
            m_cyc++;
         end
      end
   endtask

   task automatic compare_loop();
      logic [NCH-1:0] er, ef;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("reset_outputs", {data_out, rise_vec, fall_vec, edge_vec, edge_found,
                                  interval, interval_valid, idle}, 0);
         end else begin
            er = m_lvl & ~m_prev;
            ef = ~m_lvl & m_prev;
            chk("data_out", data_out, m_lvl);
            chk("rise_vec", rise_vec, er);
            chk("fall_vec", fall_vec, ef);
            chk("edge_vec", edge_vec, qualify(er, ef, edge_mode));
            chk("edge_found", edge_found, int'(qualify(er, ef, edge_mode) != '0));
            chk("interval", interval, m_interval);
            chk("interval_valid", interval_valid, m_ivalid);
            chk("idle", idle, int'(m_quiet == GMAX));
            if (edge_found) ef_cnt++;
            if (interval_valid) begin
               iv_cnt++;
               iv_last = interval;
            end
            for (int c = 0; c < NCH; c++) begin
               if (rise_vec[c]) rise_cnt[c]++;
               if (fall_vec[c]) fall_cnt[c]++;
               if (edge_vec[c]) edge_cnt[c]++;
            end
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int e0, iv0, r0, f0, g0;
      int exp_edge [3];
      exp_edge = '{1, 1, 0};
      for (int c = 0; c < NCH; c++) begin
         rise_cnt[c] = 0; fall_cnt[c] = 0; edge_cnt[c] = 0;
      end
      fork
         model_loop();
         compare_loop();
      join_none

      $display("txn reset: din toggling under reset");
      for (int i = 0; i < 6; i++) begin
         step(1);
         din = 2'(i);
      end
      chk("rst_data_out", data_out, 0);
      chk("rst_edge_found", edge_found, 0);
      din = '0;
      step(3);
      rst = 1'b1;
      e0 = ef_cnt;
      step(10);
      chk("no_edge_after_release", ef_cnt - e0, 0);

      $display("txn latency filt_en=1");
      din[0] = 1'b1;
      step(3);
      chk("lat_filt_before", rise_vec, 0);
      step(1);
      chk("lat_filt_rise", rise_vec, 1);
      chk("lat_filt_found", edge_found, 1);
      chk("lat_filt_data", data_out, 1);
      step(1);
      chk("lat_filt_one_wide", rise_vec, 0);
      din[0] = 1'b0;
      step(8);

      $display("txn latency filt_en=0");
      filt_en = 1'b0;
      step(4);
      din[0] = 1'b1;
      step(2);
      chk("lat_byp_before", rise_vec, 0);
      step(1);
      chk("lat_byp_rise", rise_vec, 1);
      chk("lat_byp_found", edge_found, 1);
      din[0] = 1'b0;
      step(6);

      $display("txn glitch one-clock pulse ch1");
      filt_en = 1'b1;
      step(4);
      e0 = ef_cnt;
      din[1] = 1'b1;
      step(1);
      din[1] = 1'b0;
      step(8);
      chk("glitch_rejected", ef_cnt - e0, 0);

      $display("txn two-clock pulse ch1");
      e0 = ef_cnt; r0 = rise_cnt[1]; f0 = fall_cnt[1];
      din[1] = 1'b1;
      step(2);
      din[1] = 1'b0;
      step(8);
      chk("pulse2_rise", rise_cnt[1] - r0, 1);
      chk("pulse2_fall", fall_cnt[1] - f0, 1);
      chk("pulse2_found", ef_cnt - e0, 2);

      for (int m = 1; m <= 3; m++) begin
         $display("txn mode %0d toggle ch0", m);
         edge_mode = 2'(m);
         r0 = rise_cnt[0]; f0 = fall_cnt[0]; g0 = edge_cnt[0];
         din[0] = 1'b1;
         step(8);
         din[0] = 1'b0;
         step(8);
         chk("mode_rise", rise_cnt[0] - r0, 1);
         chk("mode_fall", fall_cnt[0] - f0, 1);
         chk("mode_edge", edge_cnt[0] - g0, exp_edge[m-1]);
      end
      edge_mode = 2'b00;

      $display("txn interval 12 clocks, bypass");
      filt_en = 1'b0;
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      step(3);
      iv0 = iv_cnt;
      for (int k = 0; k < 4; k++) begin
         din[0] = ~din[0];
         step(12);
         if (k == 0) chk("first_edge_no_valid", iv_cnt - iv0, 0);
      end
      chk("interval_count", iv_cnt - iv0, 3);
      chk("interval_12", iv_last, 12);

      $display("txn simultaneous edges");
      iv0 = iv_cnt;
      din = 2'b11;
      step(3);
      chk("simul_edge_vec", edge_vec, 3);
      chk("simul_found", edge_found, 1);
      step(1);
      chk("simul_valid", interval_valid, 1);
      chk("simul_interval", interval, 12);
      step(8);
      chk("simul_single_capture", iv_cnt - iv0, 1);

      $display("txn consecutive-clock edges");
      din[0] = 1'b0;
      step(1);
      din[1] = 1'b0;
      step(4);
      chk("b2b_valid", interval_valid, 1);
      chk("b2b_interval", interval, 1);

      $display("txn idle after quiet period");
      step(260);
      chk("idle_set", idle, 1);
      din[0] = 1'b1;
      step(3);
      chk("idle_edge_found", edge_found, 1);
      chk("idle_still_set", idle, 1);
      step(1);
      chk("idle_cleared", idle, 0);
      chk("idle_interval_sat", interval, GMAX);

      $display("txn mode 11 with toggling lines");
      edge_mode = 2'b11;
      for (int k = 0; k < 14; k++) begin
         din[0] = ~din[0];
         step(20);
      end
      chk("mode11_idle", idle, 1);
      edge_mode = 2'b00;

      $display("txn reset during filtering");
      filt_en = 1'b1;
      step(4);
      din[1] = 1'b1;
      step(3);
      rst = 1'b0;
      step(2);
      chk("midrst_data", data_out, 0);
      chk("midrst_idle", idle, 0);
      iv0 = iv_cnt; e0 = ef_cnt;
      rst = 1'b1;
      step(10);
      chk("midrst_one_edge", ef_cnt - e0, 1);
      chk("midrst_data_after", data_out, 3);
      chk("midrst_no_valid", iv_cnt - iv0, 0);
      din[0] = 1'b0;
      step(10);
      chk("midrst_second_valid", iv_cnt - iv0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
